// File: rtl/add_accum_if.sv
// Stream bus for add_accum: sample input channel, frame-result output channel and frame length.
interface add_accum_if #(
   parameter int unsigned IN_W  = 9,
   parameter int unsigned ACC_W = 16,
   parameter int unsigned LEN_W = 8
);
   logic [LEN_W-1:0]        len;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] out_data;
   logic                    out_sat;
   logic [LEN_W-1:0]        out_count;

   modport master (
      output len, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sat, out_count
   );

   modport slave (
      input  len, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sat, out_count
   );
endinterface

// File: rtl/add_accum.sv
// Frame accumulator: sums len signed samples with saturation, then holds the
// result until the downstream handshake.
module add_accum #(
   parameter int unsigned IN_W  = 9,
   parameter int unsigned ACC_W = 16,
   parameter int unsigned LEN_W = 8
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         clear,
   add_accum_if.slave   bus
);
   localparam int unsigned SUM_W = ACC_W + 1;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t                  state,     state_nx;
   logic signed [ACC_W-1:0] acc,       acc_nx;
   logic [LEN_W-1:0]        cnt,       cnt_nx;
   logic                    sat,       sat_nx;
   logic [LEN_W-1:0]        len_eff,   len_eff_nx;
   logic                    out_valid, out_valid_nx;
   logic signed [ACC_W-1:0] out_data,  out_data_nx;
   logic                    out_sat,   out_sat_nx;
   logic [LEN_W-1:0]        out_count, out_count_nx;

   logic                    in_ready_c;
   logic                    xfer_c;
   logic signed [SUM_W-1:0] sum_c;
   logic signed [ACC_W-1:0] sum_clamp_c;
   logic                    ovf_c;

   // in_ready depends on state only, so upstream never sees a comb path from out_ready
   assign in_ready_c = (state != HOLD);
   assign xfer_c     = bus.in_valid && in_ready_c;

   // One extra bit of headroom: the top two bits disagree exactly on overflow
   always_comb begin
      sum_c       = SUM_W'(acc) + SUM_W'(bus.in_data);
      ovf_c       = (sum_c[SUM_W-1] != sum_c[ACC_W-1]);
      sum_clamp_c = sum_c[ACC_W-1:0];
      if (ovf_c) begin
         sum_clamp_c = sum_c[SUM_W-1] ? ACC_MIN : ACC_MAX;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_nx     = state;
      acc_nx       = acc;
      cnt_nx       = cnt;
      sat_nx       = sat;
      len_eff_nx   = len_eff;
      out_valid_nx = out_valid;
      out_data_nx  = out_data;
      out_sat_nx   = out_sat;
      out_count_nx = out_count;

      case (state)
         IDLE: begin
            if (xfer_c) begin
               len_eff_nx = (bus.len == '0) ? LEN_W'(1) : bus.len;
               acc_nx     = ACC_W'(bus.in_data);
               cnt_nx     = LEN_W'(1);
               sat_nx     = 1'b0;
               state_nx   = (len_eff_nx == LEN_W'(1)) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (xfer_c) begin
               acc_nx   = sum_clamp_c;
               cnt_nx   = cnt + LEN_W'(1);
               sat_nx   = sat | ovf_c;
               state_nx = (cnt_nx == len_eff) ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      if (clear) begin
         state_nx = IDLE;
         acc_nx   = '0;
         cnt_nx   = '0;
         sat_nx   = 1'b0;
      end

      // Result registers capture only on entry to HOLD and otherwise keep their value
      out_valid_nx = (state_nx == HOLD);
      if (state_nx == HOLD && state != HOLD) begin
         out_data_nx  = acc_nx;
         out_sat_nx   = sat_nx;
         out_count_nx = cnt_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         sat       <= 1'b0;
         len_eff   <= LEN_W'(1);
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
         out_count <= '0;
      end else begin
         state     <= state_nx;
         acc       <= acc_nx;
         cnt       <= cnt_nx;
         sat       <= sat_nx;
         len_eff   <= len_eff_nx;
         out_valid <= out_valid_nx;
         out_data  <= out_data_nx;
         out_sat   <= out_sat_nx;
         out_count <= out_count_nx;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data;
   assign bus.out_sat   = out_sat;
   assign bus.out_count = out_count;
endmodule

// File: tb/tb_add_accum.sv
// Randomized and directed bench for add_accum against a frame-level reference model.
module tb_add_accum;
   localparam int unsigned IN_W  = 9;
   localparam int unsigned ACC_W = 16;
   localparam int unsigned LEN_W = 8;
   localparam int AMAX = (2 ** (ACC_W - 1)) - 1;
   localparam int AMIN = -(2 ** (ACC_W - 1));

   logic clk;
   logic rst_b;
   logic clear;

   add_accum_if #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

   add_accum #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .clear (clear),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: frame in progress, pending result, and last published result
   bit m_active;
   bit m_pend;
   int m_len;
   int m_cnt;
   int m_acc;
   bit m_sat;
   int r_data;
   bit r_sat;
   int r_cnt;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_pend = 0; m_len = 1; m_cnt = 0; m_acc = 0; m_sat = 0;
      r_data = 0; r_sat = 0; r_cnt = 0;
   endtask

   // Applies the inputs present at the clock edge to the model
   task automatic model_step();
      int s;
      if (clear) begin
         m_active = 0; m_pend = 0; m_acc = 0; m_cnt = 0; m_sat = 0;
      end else if (m_pend) begin
         if (bus.out_ready) m_pend = 0;
      end else if (bus.in_valid) begin
         if (!m_active) begin
            m_len    = (bus.len == 0) ? 1 : int'(bus.len);
            m_acc    = int'(bus.in_data);
            m_cnt    = 1;
            m_sat    = 0;
            m_active = 1;
         end else begin
            s = m_acc + int'(bus.in_data);
            if (s > AMAX) begin s = AMAX; m_sat = 1; end
            if (s < AMIN) begin s = AMIN; m_sat = 1; end
            m_acc = s;
            m_cnt++;
         end
         if (m_cnt == m_len) begin
            m_pend   = 1;
            m_active = 0;
            r_data   = m_acc;
            r_sat    = m_sat;
            r_cnt    = m_cnt;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_b) model_step();
      #1;
   endtask

   task automatic send(input int d);
      bus.in_valid = 1'b1;
      bus.in_data  = IN_W'(d);
      step();
      bus.in_valid = 1'b0;
   endtask

   // Every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      chk("in_ready",  int'(bus.in_ready),  int'(!m_pend));
      chk("out_valid", int'(bus.out_valid), int'(m_pend));
      chk("out_data",  int'(bus.out_data),  r_data);
      chk("out_sat",   int'(bus.out_sat),   int'(r_sat));
      chk("out_count", int'(bus.out_count), r_cnt);
   end

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_valid"}, int'(bus.out_valid), 0);
      chk({tag, "_data"},  int'(bus.out_data),  0);
      chk({tag, "_sat"},   int'(bus.out_sat),   0);
      chk({tag, "_count"}, int'(bus.out_count), 0);
      chk({tag, "_ready"}, int'(bus.in_ready),  1);
   endtask

   function automatic int pick_len();
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0)  return 0;
      if (r == 1)  return 1;
      if (r == 19) return 255;
      return int'($urandom_range(2, 12));
   endfunction

   function automatic int pick_data();
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) return 255;
      if (r == 1) return -256;
      return int'($urandom_range(0, 511)) - 256;
   endfunction

   initial begin
      model_reset();
      rst_b        = 1'b1;
      clear        = 1'b0;
      bus.len      = '0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.out_ready = 1'b0;
      #1 rst_b = 1'b0;
      #1 chk_zero_outputs("reset");
      step();
      step();
      #1 rst_b = 1'b1;

      // Basic frame: 2 - 18 - 81
      bus.out_ready = 1'b1;
      bus.len = LEN_W'(3);
      send(2);
      send(-18);
      send(-81);
      chk("a_valid", int'(bus.out_valid), 1);
      chk("a_data",  int'(bus.out_data),  -97);
      chk("a_sat",   int'(bus.out_sat),   0);
      chk("a_count", int'(bus.out_count), 3);
      chk("a_model", r_data, -97);
      step();
      chk("a_no_b2b", int'(bus.out_valid), 0);

      // Positive and negative saturation
      bus.len = LEN_W'(255);
      for (int i = 0; i < 255; i++) send(255);
      chk("sp_data",  int'(bus.out_data),  32767);
      chk("sp_sat",   int'(bus.out_sat),   1);
      chk("sp_count", int'(bus.out_count), 255);
      step();
      bus.len = LEN_W'(200);
      for (int i = 0; i < 200; i++) send(-256);
      chk("sn_data",  int'(bus.out_data),  -32768);
      chk("sn_sat",   int'(bus.out_sat),   1);
      chk("sn_count", int'(bus.out_count), 200);
      chk("sn_model", r_data, -32768);
      step();

      // len=0 acts as one sample; then stall in HOLD with ignored input pulses
      bus.out_ready = 1'b0;
      bus.len = '0;
      send(-1);
      chk("l0_valid", int'(bus.out_valid), 1);
      chk("l0_data",  int'(bus.out_data),  -1);
      chk("l0_count", int'(bus.out_count), 1);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.in_data  = IN_W'(pick_data());
         bus.len      = LEN_W'(pick_len());
         step();
         chk("stall_ready", int'(bus.in_ready),  0);
         chk("stall_valid", int'(bus.out_valid), 1);
         chk("stall_data",  int'(bus.out_data),  -1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      chk("rel_ready", int'(bus.in_ready),  1);
      chk("rel_valid", int'(bus.out_valid), 0);

      // Clear mid-frame discards the partial frame and the sample presented with it
      bus.len = LEN_W'(4);
      send(7);
      send(8);
      clear = 1'b1;
      send(9);
      clear = 1'b0;
      chk("clr_valid", int'(bus.out_valid), 0);
      bus.len = LEN_W'(1);
      send(5);
      chk("clr_data", int'(bus.out_data), 5);
      chk("clr_sat",  int'(bus.out_sat),  0);
      step();

      // Asynchronous reset mid-frame
      bus.len = LEN_W'(4);
      send(1);
      send(2);
      #2 rst_b = 1'b0;
      model_reset();
      #1 chk_zero_outputs("rst_mid");
      step();
      #1 rst_b = 1'b1;
      bus.len = LEN_W'(2);
      send(10);
      send(20);
      chk("rst_new_data",  int'(bus.out_data),  30);
      chk("rst_new_count", int'(bus.out_count), 2);
      step();

      // Randomized traffic, len wiggling every cycle
      for (int c = 0; c < 4000; c++) begin
         clear         = ($urandom_range(0, 99) == 0);
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 1) == 1);
         bus.in_data   = IN_W'(pick_data());
         bus.len       = LEN_W'(pick_len());
         step();
      end
      clear = 1'b0;
      bus.in_valid = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/add_accum.md
ADD_ACCUM -- requirements
Module: add_accum

Interface
REQ-001 Parameters SHALL be IN_W, 9, width of signed input sample (adder sum width).
REQ-002 Parameters SHALL include ACC_W, 16, width of signed accumulator and result.
REQ-003 Parameters SHALL include LEN_W, 8, width of frame-length and count fields.
REQ-004 Port clk SHALL be input, 1 bit, rising-edge clock for all state.
REQ-005 Port rst_b SHALL be input, 1 bit, asynchronous active-low reset.
REQ-006 Port clear SHALL be input, 1 bit, synchronous frame abort.
REQ-007 Port len SHALL be input, LEN_W bits, samples per frame, sampled at frame start.
REQ-008 Port in_valid SHALL be input, 1 bit, upstream sample valid.
REQ-009 Port in_ready SHALL be output, 1 bit, block accepts sample.
REQ-010 Port in_data SHALL be input, signed IN_W bits, sample (upstream signed+unsigned adder sum).
REQ-011 Port out_valid SHALL be output, 1 bit, frame result valid.
REQ-012 Port out_ready SHALL be input, 1 bit, downstream accepts result.
REQ-013 Port out_data SHALL be output, signed ACC_W bits, accumulated frame result.
REQ-014 Port out_sat SHALL be output, 1 bit, saturation occurred in this frame.
REQ-015 Port out_count SHALL be output, LEN_W bits, samples accumulated in this frame.

Function
REQ-016 FSM SHALL have states IDLE, ACCUM, HOLD.
REQ-017 Input transfer SHALL occur only on a clk edge with in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD; it SHALL be combinational from state only.
REQ-019 IDLE transfer SHALL latch len_eff = len (len=0 treated as 1), set acc = sign-extended in_data, cnt=1, and clear sat.
REQ-020 IDLE transfer SHALL go to HOLD if len_eff=1, otherwise to ACCUM.
REQ-021 ACCUM transfer SHALL add sign-extended in_data to acc in ACC_W+1 bits and increment cnt.
REQ-022 Overflow SHALL clamp to 2^(ACC_W-1)-1 and underflow SHALL clamp to -2^(ACC_W-1); either case SHALL set sticky sat.
REQ-023 ACCUM SHALL go to HOLD on the transfer where the new cnt equals len_eff; ACCUM with no transfer SHALL hold all state.
REQ-024 len changes after frame start SHALL have no effect on the current frame.
REQ-025 In HOLD, out_valid SHALL be 1 and out_data/out_sat/out_count SHALL equal acc/sat/cnt, stable until handshake.
REQ-026 out_valid SHALL rise the cycle after the final input transfer (latency 1 cycle), registered.
REQ-027 HOLD with out_ready=1 SHALL go to IDLE next edge; out_valid SHALL be 0 the following cycle (no back-to-back result).
REQ-028 out_valid SHALL be 0 in IDLE and ACCUM; out_data SHALL keep its last value there.
REQ-029 clear=1 SHALL override all events: next state IDLE, acc=0, cnt=0, sat=0, out_valid=0, sample presented that cycle discarded.

Reset
REQ-030 rst_b=0 SHALL immediately force IDLE, acc=0, cnt=0, sat=0, len_eff=1, out_valid=0, out_data=0, out_sat=0, out_count=0.
REQ-031 Reset mid-frame or in HOLD SHALL discard the partial/pending result; no output SHALL appear after release until a new frame completes.
REQ-032 in_ready SHALL be 1 during reset (state IDLE) and the first post-reset edge SHALL be able to start a frame.

Verification
REQ-033 len=3, samples 2, -18, -81, out_ready=1 -> one cycle later out_valid=1, out_data=-97, out_sat=0, out_count=3.
REQ-034 len=255, every sample +255 -> out_data=32767, out_sat=1, out_count=255; every sample -256, len=200 -> out_data=-32768, out_sat=1.
REQ-035 len=0, single sample -1 -> HOLD after one transfer, out_data=-1, out_count=1.
REQ-036 Frame complete with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1.
REQ-037 len=4, two samples then clear=1 with in_valid=1 -> no output, next frame len=1 sample 5 -> out_data=5, out_sat=0.
REQ-038 rst_b low mid-frame (2 of 4 samples) -> all outputs 0 immediately; new frame len=2 samples 10, 20 -> out_data=30.
